alu_res_disp: RTL and testbench
===============================

Name: alu_res_disp

Overview:
- Downstream consumer of the 4-bit ALU: captures result and flags on a strobe, formats them, and drives a time-multiplexed 4-digit seven-segment display.
- Digit 0 shows the value, digit 1 the sign, digit 2 the carry flag, digit 3 the overflow flag.
- Holds the captured value steady while ALU inputs change, so board switches can be moved freely between captures.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit stays enabled (>=2).
- BLINK_DIV, 12500000, clk cycles per blink half-period (used only with OVF_BLINK_EN, >=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- res  in  4  ALU result
- car  in  1  ALU carry flag
- of   in  1  ALU overflow flag
- ctrl in  3  ALU opcode that produced res
- upd  in  1  capture strobe; level-sampled each edge
- seg_n out 8  active-low segments, bit order {dp,g,f,e,d,c,b,a}; dp always off
- an_n out 4  active-low digit enables; bit i = digit i
- cap_vld out 1  one-cycle pulse: hold registers loaded

Behaviour:
- Single clock domain, all state on rising clk; rst is synchronous and active-high and has priority over everything.
- Reset values:
  - hold regs (res, car, of, ctrl) = 0
  - scan counter = 0, digit index = 0
  - an_n = 4'b1111, seg_n = 8'hFF, cap_vld = 0
- Capture:
  - upd=1 at edge k loads all four hold regs at edge k; cap_vld=1 for the cycle after edge k.
  - Back-to-back upd reloads every cycle.
  - Inputs without upd never affect outputs.
- Format, selected from held ctrl:
  - 000 or 001 (signed mode):
    - mag = res[3] ? (~res+1) : res, 4-bit; -8 gives 1000 and displays '8'.
    - Digit 0 = mag as hex glyph 0-8.
    - Digit 1 = '-' if res[3], else blank.
  - 010 to 111 (hex mode): digit 0 = res as hex glyph 0-F; digit 1 = blank.
  - Digit 2 = '1'/'0' from held car; digit 3 = '1'/'0' from held of, in all modes.
- Glyphs, active-low with dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - '-'=BF, blank=FF
- Scan:
  - Counter runs 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
  - an_n and seg_n are registered together every cycle from the current index and hold regs (1-cycle latency), so they never disagree.
  - Exactly one an_n bit is low whenever rst=0.
- Simultaneous upd and scan terminal count: both take effect; the next output refresh uses the new hold values.
- rst mid-scan: all state returns to reset values at that edge. The first edge with rst=0 outputs an_n=1110 and the digit-0 glyph of the held value (reset hold gives C0).

Optional Feature:
- Macro: OVF_BLINK_EN
- With macro defined:
  - Blink counter (0..BLINK_DIV-1) toggles a phase bit at terminal count.
  - Phase resets to visible on rst and on every capture.
  - When held of=1 and held ctrl is 000/001, digits 0 and 1 output blank (FF) during the invisible phase; digits 2 and 3 are unaffected.
- Without macro: no blink logic; BLINK_DIV is ignored; display is always steady.

Test Plan (SCAN_DIV=4, BLINK_DIV=8):
1. Reset and release:
   - Hold rst=1 for 3 cycles → an_n=1111, seg_n=FF, cap_vld=0.
   - First edge after release → an_n=1110, seg_n=C0.
   - an_n then steps 1110→1101→1011→0111→1110, each held 4 cycles.
2. Signed add capture:
   - Stimulus: res=1101, car=1, of=0, ctrl=000, upd pulsed 1 cycle.
   - cap_vld pulses once.
   - Expected digits: d0=B0 ('3'), d1=BF ('-'), d2=F9, d3=C0.
3. Subtract extreme:
   - Stimulus: res=1000, car=0, of=1, ctrl=001, upd.
   - Expected: d0=80, d1=BF, d2=C0, d3=F9.
   - With OVF_BLINK_EN: d0/d1 read FF for 8 cycles and visible for 8, alternating; d2/d3 stay steady.
4. Hex mode and hold:
   - Stimulus: res=1011, ctrl=101, upd.
   - Expected: d0=83, d1=FF.
   - Then change res/ctrl without upd for 32 cycles → digit patterns unchanged.
5. Collision and reset mid-scan:
   - Assert upd on the scan terminal cycle → next refreshed digit uses the new value.
   - Assert rst while digit 2 is active → next edge gives an_n=1111, seg_n=FF.
   - After release, d0=C0, d1=FF, d2=C0, d3=C0.

Source files
------------

// File: rtl/alu_res_disp.sv
// Captures ALU result/flags on a strobe and drives a 4-digit multiplexed seven-segment display.
// Optional define OVF_BLINK_EN blinks the value digits while a signed-mode overflow is held.
module alu_res_disp #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] res,
  input  logic       car,
  input  logic       of,
  input  logic [2:0] ctrl,
  input  logic       upd,
  output logic [7:0] seg_n,
  output logic [3:0] an_n,
  output logic       cap_vld
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_t;

  localparam logic [7:0] GLYPH_DASH  = 8'hBF;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    logic [7:0] g;
    case (v)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  logic [3:0]        r_res;
  logic              r_car;
  logic              r_of;
  logic [2:0]        r_ctrl;
  logic              r_cap_vld;
  logic [SCAN_W-1:0] r_scan_cnt;
  digit_t            r_dig;
  digit_t            w_dig_nxt;
  logic              w_scan_tc;
  logic [7:0]        r_seg_n;
  logic [3:0]        r_an_n;

  logic              w_signed;
  logic [3:0]        w_mag;
  logic              w_blank;
  logic [7:0]        w_d0;
  logic [7:0]        w_d1;
  logic [7:0]        w_d2;
  logic [7:0]        w_d3;
  logic [7:0]        w_seg_nxt;
  logic [3:0]        w_an_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res     <= '0;
      r_car     <= 1'b0;
      r_of      <= 1'b0;
      r_ctrl    <= '0;
      r_cap_vld <= 1'b0;
    end else begin
      r_cap_vld <= upd;
      if (upd) begin
        r_res  <= res;
        r_car  <= car;
        r_of   <= of;
        r_ctrl <= ctrl;
      end
    end
  end

  assign w_scan_tc = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_dig      <= DIG0;
    end else begin
      r_scan_cnt <= w_scan_tc ? '0 : r_scan_cnt + 1'b1;
      r_dig      <= w_dig_nxt;
    end
  end

  always_comb begin
    w_dig_nxt = r_dig;
    if (w_scan_tc) begin
      case (r_dig)
        DIG0:    w_dig_nxt = DIG1;
        DIG1:    w_dig_nxt = DIG2;
        DIG2:    w_dig_nxt = DIG3;
        default: w_dig_nxt = DIG0;
      endcase
    end
  end

`ifdef OVF_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_invis;

  // Restarting on capture gives a fresh result a full visible half-period first.
  always_ff @(posedge clk) begin
    if (rst || upd) begin
      r_blink_cnt <= '0;
      r_invis     <= 1'b0;
    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_invis     <= ~r_invis;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign w_blank = r_invis && r_of && w_signed;
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_signed = (r_ctrl == 3'b000) || (r_ctrl == 3'b001);
    w_mag    = r_res[3] ? (~r_res + 4'd1) : r_res;
    w_d0     = hex_glyph(w_signed ? w_mag : r_res);
    w_d1     = (w_signed && r_res[3]) ? GLYPH_DASH : GLYPH_BLANK;
    w_d2     = hex_glyph({3'b000, r_car});
    w_d3     = hex_glyph({3'b000, r_of});
    if (w_blank) begin
      w_d0 = GLYPH_BLANK;
      w_d1 = GLYPH_BLANK;
    end
  end

  always_comb begin
    w_an_nxt  = 4'b1110;
    w_seg_nxt = w_d0;
    case (r_dig)
      DIG0: begin
        w_an_nxt  = 4'b1110;
        w_seg_nxt = w_d0;
      end
      DIG1: begin
        w_an_nxt  = 4'b1101;
        w_seg_nxt = w_d1;
      end
      DIG2: begin
        w_an_nxt  = 4'b1011;
        w_seg_nxt = w_d2;
      end
      default: begin
        w_an_nxt  = 4'b0111;
        w_seg_nxt = w_d3;
      end
    endcase
  end

  // Enable and segments share one register stage so they always refer to the same digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an_n  <= '1;
      r_seg_n <= '1;
    end else begin
      r_an_n  <= w_an_nxt;
      r_seg_n <= w_seg_nxt;
    end
  end

  assign an_n    = r_an_n;
  assign seg_n   = r_seg_n;
  assign cap_vld = r_cap_vld;

endmodule

// File: tb/tb_alu_res_disp.sv
// Bench for alu_res_disp: directed plan steps plus random traffic against a cycle-level reference model.
// Define OVF_BLINK_EN here and in the RTL build together to cover the blink option.
module tb_alu_res_disp;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLINK_DIV = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] res;
  logic       car;
  logic       of;
  logic [2:0] ctrl;
  logic       upd;
  logic [7:0] seg_n;
  logic [3:0] an_n;
  logic       cap_vld;

  alu_res_disp #(
    .SCAN_DIV (SCAN_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .res    (res),
    .car    (car),
    .of     (of),
    .ctrl   (ctrl),
    .upd    (upd),
    .seg_n  (seg_n),
    .an_n   (an_n),
    .cap_vld(cap_vld)
  );

  always #5 clk = ~clk;

  logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state: held values, edges since reset release, edges since last capture/reset.
  logic [3:0]  m_res;
  logic        m_car;
  logic        m_of;
  logic [2:0]  m_ctrl;
  int unsigned m_t;
  int unsigned m_n;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  function automatic int unsigned cur_digit();
    return (m_t / SCAN_DIV) % 4;
  endfunction

  function automatic logic [7:0] exp_seg(input int unsigned d);
    bit         sgn;
    int         sv;
    int         val;
    logic [7:0] g;
    sgn = (m_ctrl <= 3'd1);
    sv  = $signed(m_res);
    case (d)
      0: begin
        if (sgn) val = (sv < 0) ? -sv : sv;
        else     val = int'(m_res);
        g = GLYPH[val];
      end
      1:       g = (sgn && sv < 0) ? 8'hBF : 8'hFF;
      2:       g = m_car ? GLYPH[1] : GLYPH[0];
      default: g = m_of ? GLYPH[1] : GLYPH[0];
    endcase
`ifdef OVF_BLINK_EN
    if (d < 2 && sgn && m_of && ((m_n / BLINK_DIV) % 2 == 1)) g = 8'hFF;
`endif
    return g;
  endfunction

  task automatic tick();
    logic [3:0]  ea;
    logic [7:0]  es;
    logic        ec;
    int unsigned d;
    if (rst) begin
      ea = 4'b1111;
      es = 8'hFF;
      ec = 1'b0;
    end else begin
      d  = cur_digit();
      ea = ~(4'b0001 << d);
      es = exp_seg(d);
      ec = upd;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    assert (an_n === ea) else begin
      n_err++;
      $error("FAIL an_n t=%0d got %b want %b", m_t, an_n, ea);
    end
    n_cmp++;
    assert (seg_n === es) else begin
      n_err++;
      $error("FAIL seg_n t=%0d got %h want %h", m_t, seg_n, es);
    end
    n_cmp++;
    assert (cap_vld === ec) else begin
      n_err++;
      $error("FAIL cap_vld t=%0d got %b want %b", m_t, cap_vld, ec);
    end
    if (rst) begin
      m_res  = '0;
      m_car  = 1'b0;
      m_of   = 1'b0;
      m_ctrl = '0;
      m_t    = 0;
      m_n    = 0;
    end else begin
      if (upd) begin
        m_res  = res;
        m_car  = car;
        m_of   = of;
        m_ctrl = ctrl;
        m_n    = 0;
      end else begin
        m_n++;
      end
      m_t++;
    end
    @(negedge clk);
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic capture(input logic [3:0] r, input logic c, input logic o, input logic [2:0] op);
    res  = r;
    car  = c;
    of   = o;
    ctrl = op;
    upd  = 1'b1;
    tick();
    upd  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; res = '0; car = 1'b0; of = 1'b0; ctrl = '0; upd = 1'b0;
    m_res = '0; m_car = 1'b0; m_of = 1'b0; m_ctrl = '0; m_t = 0; m_n = 0;
    @(negedge clk);

    // Reset and release, full scan walk
    ticks(3);
    rst = 1'b0;
    ticks(20);

    // Signed add capture: -3 with carry
    capture(4'b1101, 1'b1, 1'b0, 3'b000);
    ticks(20);

    // Subtract extreme: -8 with overflow
    capture(4'b1000, 1'b0, 1'b1, 3'b001);
    ticks(40);

    // Hex mode, then free-running inputs without strobe
    capture(4'b1011, 1'b0, 1'b0, 3'b101);
    for (int unsigned i = 0; i < 32; i++) begin
      res  = 4'($urandom);
      car  = 1'($urandom);
      of   = 1'($urandom);
      ctrl = 3'($urandom);
      tick();
    end

    // Capture on the scan terminal cycle
    for (int unsigned i = 0; i < SCAN_DIV && (m_t % SCAN_DIV) != SCAN_DIV - 1; i++) tick();
    capture(4'b0110, 1'b1, 1'b1, 3'b000);
    ticks(16);

    // Reset while digit 2 is on
    for (int unsigned i = 0; i < 4 * SCAN_DIV && cur_digit() != 2; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(20);

    // Random traffic including back-to-back strobes and occasional reset
    for (int unsigned i = 0; i < 400; i++) begin
      res  = 4'($urandom);
      car  = 1'($urandom);
      of   = 1'($urandom);
      ctrl = 3'($urandom);
      upd  = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;
    upd = 1'b0;
    ticks(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
